// File: rtl/grad_spi_serialiser.sv
// grad_spi_serialiser
// Serialises gradient DAC words from grad_bram onto a 4-chip-select SPI bus
// (mode 0, MSB first). A one-deep pending buffer absorbs one word that
// arrives while a frame is in flight. Any further word is dropped and the
// sticky overflow flag is raised.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   data_i      [FRAME_BITS-1:0] payload, [25:24] DAC select, [31:26] ignored
//   valid_i     one-cycle strobe qualifying data_i
//   busy_o      frame in flight or word pending
//   sclk_o      SPI clock, idle low
//   mosi_o      SPI data, MSB first
//   ssn_o       active-low chip selects, one per DAC
//   overflow_o  sticky: a word was dropped
module grad_spi_serialiser #(
  parameter int SCLK_DIV   = 2,
  parameter int FRAME_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic [3:0]  ssn_o,
  output logic        overflow_o
);

  localparam logic [7:0] DIV_RELOAD = 8'(SCLK_DIV - 1);
  localparam logic [4:0] BIT_TOP    = 5'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                  state, state_n;
  logic [7:0]              cnt, cnt_n;
  logic [4:0]              bit_cnt, bit_n;
  logic [FRAME_BITS-1:0]   shreg, shreg_n;
  logic                    pend_full, pend_full_n;
  logic [1:0]              pend_sel, pend_sel_n;
  logic [FRAME_BITS-1:0]   pend_pay, pend_pay_n;
  logic                    sclk_n, mosi_n, busy_n, ovf_n;
  logic [3:0]              ssn_n;
  logic                    cnt_zero;
  logic                    start;
  logic [1:0]              start_sel;
  logic [FRAME_BITS-1:0]   start_pay;
  logic                    direct;
  logic                    unused_bits;

  assign cnt_zero    = (cnt == 8'd0);
  assign unused_bits = ^data_i[31:26];

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_n       = bit_cnt;
    shreg_n     = shreg;
    sclk_n      = sclk_o;
    mosi_n      = mosi_o;
    ssn_n       = ssn_o;
    pend_full_n = pend_full;
    pend_sel_n  = pend_sel;
    pend_pay_n  = pend_pay;
    ovf_n       = overflow_o;
    start       = 1'b0;
    start_sel   = data_i[25:24];
    start_pay   = data_i[FRAME_BITS-1:0];

    case (state)
      IDLE: begin
        mosi_n = 1'b0;
        start  = valid_i;
      end
      SETUP: begin
        if (cnt_zero) begin
          state_n = SHIFT;
          cnt_n   = DIV_RELOAD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      SHIFT: begin
        // sclk starts low, so the frame ends on the last falling edge
        if (cnt_zero) begin
          cnt_n = DIV_RELOAD;
          if (!sclk_o) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == 5'd0) begin
              state_n = HOLD;
            end else begin
              bit_n   = bit_cnt - 5'd1;
              shreg_n = shreg << 1;
              mosi_n  = shreg[FRAME_BITS-2];
            end
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_n = GAP;
          cnt_n   = DIV_RELOAD;
          ssn_n   = 4'hF;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (pend_full) begin
            start       = 1'b1;
            start_sel   = pend_sel;
            start_pay   = pend_pay;
            pend_full_n = 1'b0;
          end else if (valid_i) begin
            start = 1'b1;
          end else begin
            state_n = IDLE;
            mosi_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A word arriving at the end of GAP with nothing pending starts the next
    // frame directly rather than detouring through IDLE.
    direct = (state == IDLE) || (state == GAP && cnt_zero && !pend_full);
    if (valid_i && !direct) begin
      if (!pend_full_n) begin
        pend_full_n = 1'b1;
        pend_sel_n  = data_i[25:24];
        pend_pay_n  = data_i[FRAME_BITS-1:0];
      end else begin
        ovf_n = 1'b1;
      end
    end

    if (start) begin
      state_n = SETUP;
      cnt_n   = DIV_RELOAD;
      bit_n   = BIT_TOP;
      shreg_n = start_pay;
      mosi_n  = start_pay[FRAME_BITS-1];
      sclk_n  = 1'b0;
      ssn_n   = ~(4'b0001 << start_sel);
    end

    busy_n = (state_n != IDLE) || pend_full_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      bit_cnt    <= 5'd0;
      shreg      <= '0;
      pend_full  <= 1'b0;
      pend_sel   <= 2'd0;
      pend_pay   <= '0;
      sclk_o     <= 1'b0;
      mosi_o     <= 1'b0;
      ssn_o      <= 4'hF;
      busy_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      pend_full  <= pend_full_n;
      pend_sel   <= pend_sel_n;
      pend_pay   <= pend_pay_n;
      sclk_o     <= sclk_n;
      mosi_o     <= mosi_n;
      ssn_o      <= ssn_n;
      busy_o     <= busy_n;
      overflow_o <= ovf_n;
    end
  end

endmodule
